// File: rtl/bnn_pkg.sv
// Shared constants and FSM state type for the BNN window feeder.
package bnn_pkg;

   localparam int DATA_W = 16;
   localparam int WIN    = 5;
   localparam int N_WIN  = 36;
   localparam int CNT_W  = 6;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STREAM,
      DONE
   } feeder_state_t;

endpackage

// File: rtl/bnn_shift_window.sv
// WIN-deep sample shift register; lane 0 holds the oldest sample, lane WIN-1 the newest.
module bnn_shift_window
   import bnn_pkg::*;
#(
   parameter int DATA_W = bnn_pkg::DATA_W,
   parameter int WIN    = bnn_pkg::WIN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  shift_en,
   input  logic [DATA_W-1:0]     din,
   output logic [WIN*DATA_W-1:0] win
);

   // New samples enter at the top lane and push the oldest one out of lane 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win <= '0;
      end else if (clr) begin
         win <= '0;
      end else if (shift_en) begin
         win <= {din, win[WIN*DATA_W-1:DATA_W]};
      end
   end

endmodule

// File: rtl/bnn_window_feeder.sv
// Turns a sample stream into N_WIN overlapping WIN-sample windows per block for the conv engine.
module bnn_window_feeder
   import bnn_pkg::*;
#(
   parameter int DATA_W = bnn_pkg::DATA_W,
   parameter int WIN    = bnn_pkg::WIN,
   parameter int N_WIN  = bnn_pkg::N_WIN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [DATA_W-1:0]     s_data,
   output logic                  s_ready,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [WIN*DATA_W-1:0] win_data,
   output logic [5:0]            win_idx,
   output logic                  win_last,
   output logic                  block_done,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIN - 1 + N_WIN);
   localparam logic [5:0]       IDX_LAST  = 6'(N_WIN - 1);

   feeder_state_t    state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             win_valid_nxt;
   logic             s_acc;
   logic             w_hs;
   logic             clr;

   assign s_acc      = s_valid && s_ready;
   assign w_hs       = win_valid && win_ready;
   assign clr        = (state == IDLE) && start;
   assign win_last   = win_valid && (win_idx == IDX_LAST);
   assign block_done = (state == DONE);
   assign busy       = (state != IDLE);

   bnn_shift_window #(
      .DATA_W (DATA_W),
      .WIN    (WIN)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .shift_en (s_acc),
      .din      (s_data),
      .win      (win_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         win_idx   <= '0;
         win_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         win_valid <= win_valid_nxt;
         if (clr) begin
            cnt     <= '0;
            win_idx <= '0;
         end else begin
            if (s_acc) begin
               cnt <= cnt + 1'b1;
            end
            if (w_hs) begin
               win_idx <= win_idx + 1'b1;
            end
         end
      end
   end

   // A held window blocks new samples so the pending window never changes under the consumer.
   always_comb begin
      s_ready       = 1'b0;
      state_nxt     = state;
      win_valid_nxt = win_valid;
      case (state)
         IDLE: begin
            win_valid_nxt = 1'b0;
            if (start) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            s_ready = 1'b1;
            if (s_acc && (cnt == FILL_LAST)) begin
               state_nxt     = STREAM;
               win_valid_nxt = 1'b1;
            end
         end
         STREAM: begin
            s_ready = (!win_valid || win_ready) && (cnt < CNT_MAX);
            if (s_acc) begin
               win_valid_nxt = 1'b1;
            end else if (w_hs) begin
               win_valid_nxt = 1'b0;
            end
            if (w_hs && win_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            win_valid_nxt = 1'b0;
            state_nxt     = IDLE;
         end
         default: begin
            state_nxt     = IDLE;
            win_valid_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bnn_window_feeder.sv
// Self-checking bench for bnn_window_feeder against a sample-list window model.
module tb_bnn_window_feeder;

   localparam int DATA_W = 16;
   localparam int WIN    = 5;
   localparam int N_WIN  = 36;
   localparam int N_SMP  = WIN - 1 + N_WIN;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic                  s_valid = 1'b0;
   logic [DATA_W-1:0]     s_data = '0;
   logic                  s_ready;
   logic                  win_valid;
   logic                  win_ready = 1'b0;
   logic [WIN*DATA_W-1:0] win_data;
   logic [5:0]            win_idx;
   logic                  win_last;
   logic                  block_done;
   logic                  busy;

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] sent [N_SMP];

   bnn_window_feeder #(
      .DATA_W (DATA_W),
      .WIN    (WIN),
      .N_WIN  (N_WIN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .win_idx    (win_idx),
      .win_last   (win_last),
      .block_done (block_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_s_ready"}, 128'(s_ready), 128'(0));
      checkOutput({tag, "_win_valid"}, 128'(win_valid), 128'(0));
      checkOutput({tag, "_win_data"}, 128'(win_data), 128'(0));
      checkOutput({tag, "_win_idx"}, 128'(win_idx), 128'(0));
      checkOutput({tag, "_win_last"}, 128'(win_last), 128'(0));
      checkOutput({tag, "_block_done"}, 128'(block_done), 128'(0));
      checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
   endtask

   // Runs one block. Window n is expected to hold sent[n..n+WIN-1], oldest in lane 0.
   // validMode/readyMode: 0 always on, 1 patterned (alternate / stall at window 10), 2 random.
   task automatic applyStimulus(input bit randData, input logic [DATA_W-1:0] base,
                                input int validMode, input int readyMode, input int startAt,
                                input int abortAfter, input bit extras);
      int sentIdx = 0;
      int winCount = 0;
      int cyc = 0;
      int stallLeft = 3;
      int lastHs = -10;
      bit finished = 0;
      bit gotDone = 0;
      bit pend = 0;
      bit prevStall = 0;
      bit vOn;
      logic [DATA_W-1:0] pendData = '0;
      logic [WIN*DATA_W-1:0] prevData = '0;
      logic [WIN*DATA_W-1:0] expWin;
      logic [5:0] prevIdx = '0;

      for (int i = 0; i < N_SMP; i++) begin
         sent[i] = randData ? DATA_W'($urandom) : base + DATA_W'(i);
      end

      @(negedge clk);
      start = 1'b1;
      s_valid = 1'b0;
      win_ready = 1'b0;
      @(posedge clk);

      while (!finished && cyc < 3000) begin
         @(negedge clk);
         start = (cyc == startAt);

         if (pend) begin
            checkOutput("latency_valid", 128'(win_valid), 128'(1));
            checkOutput("latency_newest", 128'(win_data[WIN*DATA_W-1 -: DATA_W]), 128'(pendData));
            pend = 0;
         end
         if (prevStall) begin
            checkOutput("stall_valid", 128'(win_valid), 128'(1));
            checkOutput("stall_data", 128'(win_data), 128'(prevData));
            checkOutput("stall_idx", 128'(win_idx), 128'(prevIdx));
         end

         case (validMode)
            0:       vOn = 1'b1;
            1:       vOn = (cyc % 2 == 0);
            default: vOn = ($urandom_range(0, 2) != 0);
         endcase
         s_valid = (sentIdx < N_SMP) ? vOn : extras;
         s_data  = (sentIdx < N_SMP) ? sent[sentIdx] : 16'hdead;

         case (readyMode)
            0: win_ready = 1'b1;
            1: begin
               if (win_valid && winCount == 10 && stallLeft > 0) begin
                  win_ready = 1'b0;
                  stallLeft--;
               end else begin
                  win_ready = 1'b1;
               end
            end
            default: win_ready = ($urandom_range(0, 2) != 0);
         endcase
         #1;

         checkOutput("busy", 128'(busy), 128'(1));
         if (win_valid && !win_ready) checkOutput("s_ready_stall", 128'(s_ready), 128'(0));
         if (sentIdx >= N_SMP) checkOutput("s_ready_after_last", 128'(s_ready), 128'(0));
         if (win_valid) checkOutput("win_last", 128'(win_last), 128'(winCount == N_WIN - 1));
         if (win_valid && win_ready) begin
            for (int k = 0; k < WIN; k++) begin
               expWin[k*DATA_W +: DATA_W] = sent[(winCount + k) % N_SMP];
            end
            checkOutput("win_data", 128'(win_data), 128'(expWin));
            checkOutput("win_idx", 128'(win_idx), 128'(winCount));
            lastHs = cyc;
            winCount++;
         end
         if (block_done) begin
            checkOutput("done_timing", 128'(cyc - lastHs), 128'(1));
            checkOutput("done_windows", 128'(winCount), 128'(N_WIN));
            checkOutput("done_samples", 128'(sentIdx), 128'(N_SMP));
            finished = 1;
            gotDone = 1;
         end

         prevStall = win_valid && !win_ready;
         prevData  = win_data;
         prevIdx   = win_idx;
         if (s_valid && s_ready && sentIdx < N_SMP) begin
            if (sentIdx >= WIN - 1) begin
               pend = 1;
               pendData = s_data;
            end
            sentIdx++;
         end
         if (abortAfter > 0 && sentIdx == abortAfter) finished = 1;
         @(posedge clk);
         cyc++;
      end

      if (!finished) checkOutput("timeout", 128'(0), 128'(1));
      if (gotDone) begin
         @(negedge clk);
         s_valid = extras;
         #1;
         checkOutput("idle_busy", 128'(busy), 128'(0));
         checkOutput("idle_s_ready", 128'(s_ready), 128'(0));
         checkOutput("idle_done_pulse", 128'(block_done), 128'(0));
         checkOutput("idle_win_valid", 128'(win_valid), 128'(0));
      end
      @(negedge clk);
      s_valid = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      #1;
      checkAllZero("reset");
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] back-to-back block, samples 1..40");
      applyStimulus(0, 16'd1, 0, 0, -1, 0, 0);
      $display("[TB] consumer stall at window 10");
      applyStimulus(0, 16'd1, 0, 1, -1, 0, 0);
      $display("[TB] s_valid every other cycle");
      applyStimulus(0, 16'd1, 1, 0, -1, 0, 0);
      $display("[TB] start pulsed during STREAM");
      applyStimulus(0, 16'd1, 0, 0, 10, 0, 0);
      $display("[TB] reset after 20 samples");
      applyStimulus(0, 16'd1, 0, 0, -1, 20, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 16'd100, 0, 0, -1, 0, 0);
      $display("[TB] extra samples after the 40th");
      applyStimulus(0, 16'd1, 0, 0, -1, 0, 1);
      $display("[TB] random data with random valid/ready");
      for (int r = 0; r < 3; r++) begin
         applyStimulus(1, 16'd0, 2, 2, -1, 0, r == 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bnn_window_feeder.md
BNN_WINDOW_FEEDER -- requirements
Module: bnn_window_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter WIN, default 5, meaning samples per window (one conv frame).
REQ-003 SHALL have parameter N_WIN, default 36, meaning windows per block.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle pulse that begins a block.
REQ-007 SHALL have port s_valid  input  1  upstream sample valid.
REQ-008 SHALL have port s_data  input  DATA_W  signed upstream sample.
REQ-009 SHALL have port s_ready  output  1  sample accepted when s_valid and s_ready are both high.
REQ-010 SHALL have port win_valid  output  1  window valid toward the conv engine.
REQ-011 SHALL have port win_ready  input  1  conv engine accepts the window.
REQ-012 SHALL have port win_data  output  WIN*DATA_W  window; lane k (bits k*DATA_W upward, k=0..WIN-1) is the k-th oldest sample and maps to conv lane k+1.
REQ-013 SHALL have port win_idx  output  6  index 0..N_WIN-1 of the current window.
REQ-014 SHALL have port win_last  output  1  high when win_valid is high and win_idx equals N_WIN-1.
REQ-015 SHALL have port block_done  output  1  single-cycle pulse at block end.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, FILL, STREAM and DONE.
REQ-018 IDLE: s_ready=0 and win_valid=0; start moves the FSM to FILL and clears the sample counter, win_idx and the window register.
REQ-019 FILL: s_ready=1; each accepted sample shifts in at the newest lane; on acceptance of the WIN-th sample, the FSM moves to STREAM and win_valid rises on the next cycle.
REQ-020 Latency from acceptance of a sample to the window that contains it SHALL be exactly 1 cycle.
REQ-021 STREAM: s_ready = (!win_valid || win_ready) && (sample counter < WIN-1+N_WIN); total samples accepted per block is 40 at default parameters.
REQ-022 A window handshake (win_valid && win_ready) SHALL increment win_idx; win_valid SHALL fall unless a new sample is accepted in the same cycle.
REQ-023 Simultaneous window handshake and sample acceptance SHALL present the shifted window on the next cycle with win_valid held high and no bubble.
REQ-024 While win_valid=1 and win_ready=0, win_data, win_idx and win_valid SHALL hold stable and s_ready SHALL be 0.
REQ-025 The handshake with win_last=1 SHALL move the FSM to DONE; in DONE, block_done=1 for exactly one cycle, and the FSM then returns to IDLE.
REQ-026 start SHALL be ignored in every state except IDLE.
REQ-027 Gaps on s_valid SHALL stall the FSM without changing any state or output.
REQ-028 The sample counter SHALL be 6 bits wide, and it SHALL never wrap within a block.

Reset
REQ-029 Asserting rst_n low SHALL immediately force IDLE, s_ready=0, win_valid=0, win_data=0, win_idx=0, win_last=0, block_done=0, busy=0 and counter=0.
REQ-030 Reset in mid-block SHALL discard the partial block, and a later start SHALL begin a clean fill.

Structure
REQ-031 The shared package bnn_pkg SHALL hold DATA_W, WIN, N_WIN and the FSM state typedef.
REQ-032 The WIN-deep shift register SHALL be the sub-module bnn_shift_window (inputs shift_en and din; output the packed window).

Verification
REQ-033 Verification SHALL cover: start, s_data=1..40 back-to-back, win_ready=1 -> 36 windows with window 0 lanes {1,2,3,4,5} and window 35 lanes {36..40}, win_last on idx 35, and block_done one cycle after the last handshake.
REQ-034 Verification SHALL cover: win_ready low for 3 cycles at window 10 -> win_data (lanes 11..15) and win_idx stable, s_ready=0, and no sample lost.
REQ-035 Verification SHALL cover: s_valid toggling every other cycle -> the same 36 windows with correct contents and gaps on win_valid only.
REQ-036 Verification SHALL cover: start pulsed during STREAM -> no effect, and the block completes normally.
REQ-037 Verification SHALL cover: rst_n low after 20 samples -> all outputs 0; then start and samples 100..139 -> window 0 = {100..104}.
REQ-038 Verification SHALL cover: exactly 40 s_valid samples followed by extra s_valid -> s_ready=0 after the 40th sample, and the extras are not accepted.
